fp_accumulator: RTL and testbench

- Downstream stage of the floating-point multiplier in the neuron datapath.
- Consumes the multiplier's product stream (one-cycle valid strobe, no back-pressure) and sums each group of `len` products in IEEE-754 format (round-to-nearest-even).
- Emits one sum per group with a one-cycle strobe to the activation stage.
- Uses a multi-cycle FSM adder with a one-entry skid register, so products arriving mid-add are not lost.

---
 rtl/fp_accumulator.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fp_accumulator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// fp_accumulator
//   Sums each group of `len` IEEE-754 products from the multiplier and
//   emits one result per group. Rounding is round-to-nearest-even and
//   subnormals are flushed to zero. The adder is a multi-cycle FSM. A
//   one-entry skid register holds a product that arrives while an add is
//   still in progress.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   input_p        product word from the multiplier
//   input_p_stb    one-cycle product valid (no back-pressure)
//   len            products per group, sampled with the first product (0 -> 1)
//   output_sum     accumulated group sum
//   output_sum_stb one-cycle strobe per finished group
//   busy           FSM not idle in get_p, or skid register occupied
//   overrun        sticky: a product was dropped (cleared only by rst)
module fp_accumulator #(
    parameter int n           = 32,
    parameter int exponent    = 8,
    parameter int fraction    = 23,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n-1:0]           input_p,
    input  logic                   input_p_stb,
    input  logic [count_width-1:0] len,
    output logic [n-1:0]           output_sum,
    output logic                   output_sum_stb,
    output logic                   busy,
    output logic                   overrun
);

    // Internal exponent is two bits wider and signed; mantissa carries
    // hidden bit + fraction + guard/round/sticky.
    localparam int EW   = exponent + 2;
    localparam int MW   = fraction + 4;
    localparam int BIAS = (1 << (exponent - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MIN  = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [count_width-1:0] CNT_ONE = count_width'(1);
    localparam logic [n-1:0] NAN_WORD = {1'b1, {exponent{1'b1}}, 1'b1, {(fraction-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_P, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1, NORMALISE, ROUND, PACK, PUT_SUM
    } state_t;

    // Round-to-nearest-even on {hidden,fraction,g,r,s}; MSB of the result
    // is the mantissa carry-out.
    function automatic logic [fraction+1:0] round_rne(input logic [MW-1:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[MW-1:3]} + (fraction+2)'(up);
    endfunction

    // Overflow saturates to signed infinity; a missing hidden bit can only
    // remain at the minimum exponent, which flushes to signed zero.
    function automatic logic [n-1:0] pack_fp(input logic s,
                                             input logic signed [EW-1:0] e,
                                             input logic [fraction:0] m);
        logic signed [EW-1:0] be;
        be = e + BIAS_E;
        if (e > E_MAX)
            return {s, {exponent{1'b1}}, {fraction{1'b0}}};
        if (!m[fraction])
            return {s, {(n-1){1'b0}}};
        return {s, be[exponent-1:0], m[fraction-1:0]};
    endfunction

    state_t                   state;
    logic                     skid_full;
    logic [n-1:0]             skid_p;
    logic [count_width-1:0]   skid_len;
    logic [count_width-1:0]   grp_len;
    logic [count_width-1:0]   term_cnt;
    logic [n-1:0]             acc;
    logic [n-1:0]             op_a, op_b;
    logic                     a_s, b_s, z_s;
    logic signed [EW-1:0]     a_e, b_e, z_e;
    logic [MW-1:0]            a_m, b_m;
    logic [MW:0]              z_m;
    logic [fraction:0]        r_m;
    logic [fraction+1:0]      rnd;

    logic drain;
    logic norm_shift;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic special_hit;
    logic [n-1:0] special_word;
    logic [n-1:0] result_word;

    assign drain      = (state == GET_P) && skid_full;
    assign norm_shift = !z_m[MW-1] && (z_e > E_MIN);
    assign rnd        = round_rne(z_m[MW-1:0]);
    assign busy       = (state != GET_P) || skid_full;

    // Operand classification straight from the raw words; the words stay
    // stable for the whole add, so this is valid from SPECIAL through PACK.
    assign a_zero = ~|op_a[n-2:fraction];
    assign b_zero = ~|op_b[n-2:fraction];
    assign a_nan  = (&op_a[n-2:fraction]) && (|op_a[fraction-1:0]);
    assign b_nan  = (&op_b[n-2:fraction]) && (|op_b[fraction-1:0]);
    assign a_inf  = (&op_a[n-2:fraction]) && !(|op_a[fraction-1:0]);
    assign b_inf  = (&op_b[n-2:fraction]) && !(|op_b[fraction-1:0]);
    assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    always_comb begin
        special_word = op_b;
        if (a_nan || b_nan || (a_inf && b_inf && (op_a[n-1] != op_b[n-1])))
            special_word = NAN_WORD;
        else if (a_inf)
            special_word = op_a;
        else if (b_inf)
            special_word = op_b;
        else if (a_zero && b_zero)
            special_word = {op_a[n-1] & op_b[n-1], {(n-1){1'b0}}};
        else if (a_zero)
            special_word = op_b;
        else if (b_zero)
            special_word = op_a;
    end

    assign result_word = special_hit ? special_word : pack_fp(z_s, z_e, r_m);

    // Control: FSM sequencing, skid occupancy, group bookkeeping, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= GET_P;
            skid_full      <= 1'b0;
            overrun        <= 1'b0;
            term_cnt       <= '0;
            grp_len        <= CNT_ONE;
            acc            <= '0;
            output_sum     <= '0;
            output_sum_stb <= 1'b0;
        end else begin
            output_sum_stb <= 1'b0;

            // A capture in the same cycle as a drain keeps the entry full
            // with the new product.
            if (input_p_stb) begin
                if (!skid_full || drain)
                    skid_full <= 1'b1;
                else
                    overrun <= 1'b1;
            end else if (drain) begin
                skid_full <= 1'b0;
            end

            case (state)
                GET_P: begin
                    if (skid_full) begin
                        if (term_cnt == '0) begin
                            grp_len <= (skid_len == '0) ? CNT_ONE : skid_len;
                            acc     <= '0;
                        end
                        state <= UNPACK;
                    end
                end
                UNPACK:    state <= SPECIAL;
                SPECIAL:   state <= special_hit ? PACK : ALIGN;
                ALIGN:     if (a_e == b_e) state <= ADD_0;
                ADD_0:     state <= ADD_1;
                ADD_1:     state <= NORMALISE;
                NORMALISE: if (!norm_shift) state <= ROUND;
                ROUND:     state <= PACK;
                PACK: begin
                    acc      <= result_word;
                    term_cnt <= term_cnt + CNT_ONE;
                    state    <= ((term_cnt + CNT_ONE) == grp_len) ? PUT_SUM : GET_P;
                end
                PUT_SUM: begin
                    output_sum     <= acc;
                    output_sum_stb <= 1'b1;
                    term_cnt       <= '0;
                    state          <= GET_P;
                end
                default: state <= GET_P;
            endcase
        end
    end

    // Datapath: operand words, unpacked fields and the working sum.
    always_ff @(posedge clk) begin
        if (input_p_stb && (!skid_full || drain)) begin
            skid_p   <= input_p;
            skid_len <= len;
        end

        case (state)
            // get_p -> unpack: operand a is the running sum, b the product
            GET_P: begin
                if (skid_full) begin
                    op_b <= skid_p;
                    op_a <= (term_cnt == '0) ? '0 : acc;
                end
            end
            // unpack -> special: exponent field 0 flushes to zero
            UNPACK: begin
                a_s <= op_a[n-1];
                b_s <= op_b[n-1];
                if (a_zero) begin
                    a_e <= E_MIN;
                    a_m <= '0;
                end else begin
                    a_e <= $signed({2'b00, op_a[n-2:fraction]}) - BIAS_E;
                    a_m <= {1'b1, op_a[fraction-1:0], 3'b000};
                end
                if (b_zero) begin
                    b_e <= E_MIN;
                    b_m <= '0;
                end else begin
                    b_e <= $signed({2'b00, op_b[n-2:fraction]}) - BIAS_E;
                    b_m <= {1'b1, op_b[fraction-1:0], 3'b000};
                end
            end
            // align -> add_0: one right shift per cycle, sticky collects
            ALIGN: begin
                if (a_e < b_e) begin
                    a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
                    a_e <= a_e + ONE_E;
                end else if (b_e < a_e) begin
                    b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
                    b_e <= b_e + ONE_E;
                end
            end
            // add_0 -> add_1: exact cancellation is forced to +0
            ADD_0: begin
                z_e <= a_e;
                if (a_s == b_s) begin
                    z_m <= {1'b0, a_m} + {1'b0, b_m};
                    z_s <= a_s;
                end else if (a_m > b_m) begin
                    z_m <= {1'b0, a_m} - {1'b0, b_m};
                    z_s <= a_s;
                end else if (b_m > a_m) begin
                    z_m <= {1'b0, b_m} - {1'b0, a_m};
                    z_s <= b_s;
                end else begin
                    z_m <= '0;
                    z_s <= 1'b0;
                end
            end
            // add_1 -> normalise: fold carry-out back into range
            ADD_1: begin
                if (z_m[MW]) begin
                    z_m <= {1'b0, z_m[MW:2], z_m[1] | z_m[0]};
                    z_e <= z_e + ONE_E;
                end
            end
            // normalise -> round: one left shift per cycle, floor at E_MIN
            NORMALISE: begin
                if (norm_shift) begin
                    z_m <= {z_m[MW-1:0], 1'b0};
                    z_e <= z_e - ONE_E;
                end
            end
            // round -> pack
            ROUND: begin
                if (rnd[fraction+1]) begin
                    r_m <= rnd[fraction+1:1];
                    z_e <= z_e + ONE_E;
                end else begin
                    r_m <= rnd[fraction:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator
//   Directed-vector bench for fp_accumulator: reset values, group sums,
//   rounding ties, special operands, skid overrun and reset mid-add.
module tb_fp_accumulator;

    logic        clk;
    logic        rst;
    logic [31:0] input_p;
    logic        input_p_stb;
    logic [7:0]  len;
    logic [31:0] output_sum;
    logic        output_sum_stb;
    logic        busy;
    logic        overrun;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          stb_cnt = 0;
    logic [31:0] last_sum = '0;

    fp_accumulator #(
        .n(32), .exponent(8), .fraction(23), .count_width(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .input_p       (input_p),
        .input_p_stb   (input_p_stb),
        .len           (len),
        .output_sum    (output_sum),
        .output_sum_stb(output_sum_stb),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (output_sum_stb) begin
            stb_cnt  <= stb_cnt + 1;
            last_sum <= output_sum;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic [7:0] l);
        input_p     = p;
        len         = l;
        input_p_stb = 1'b1;
        tick();
        input_p_stb = 1'b0;
    endtask

    task automatic wait_sum(input string tag, input int start, input logic [31:0] exp);
        int i;
        i = 0;
        while (stb_cnt == start && i < 500) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check_vec({tag, "_stb"}, 32'(stb_cnt - start), 32'd1);
        check_vec(tag, last_sum, exp);
    endtask

    task automatic run_pair(input string tag, input logic [31:0] p0,
                            input logic [31:0] p1, input logic [31:0] exp);
        int start;
        start = stb_cnt;
        send(p0, 8'd2);
        repeat (14) tick();
        send(p1, 8'd2);
        wait_sum(tag, start, exp);
    endtask

    initial begin
        int start;
        rst         = 1'b1;
        input_p     = '0;
        input_p_stb = 1'b0;
        len         = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_vec("rst_sum",     output_sum,            32'h0);
        check_vec("rst_stb",     32'(output_sum_stb),   32'h0);
        check_vec("rst_busy",    32'(busy),             32'h0);
        check_vec("rst_overrun", 32'(overrun),          32'h0);

        // 1.0 + 2.0 with a busy check while the add runs
        start = stb_cnt;
        send(32'h3F800000, 8'd2);
        repeat (14) tick();
        send(32'h40000000, 8'd2);
        tick();
        check_vec("busy_mid_add", 32'(busy), 32'h1);
        wait_sum("sum_3p0", start, 32'h40400000);
        check_vec("no_overrun", 32'(overrun), 32'h0);

        run_pair("cancel",     32'h3FC00000, 32'hBFC00000, 32'h00000000);
        run_pair("tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000);
        run_pair("round_up",   32'h3F800000, 32'h33C00000, 32'h3F800001);
        run_pair("inf_m_inf",  32'h7F800000, 32'hFF800000, 32'hFFC00000);
        run_pair("nan_in",     32'h7FC00000, 32'h3F800000, 32'hFFC00000);
        run_pair("ovf_inf",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);

        // len of 0 behaves as a single-product group
        start = stb_cnt;
        send(32'h40000000, 8'd0);
        wait_sum("len_zero", start, 32'h40000000);

        // Three products two cycles apart: the third finds the skid full
        start = stb_cnt;
        send(32'h3F800000, 8'd3);
        tick();
        send(32'h3F800000, 8'd3);
        tick();
        send(32'h3F800000, 8'd3);
        tick();
        check_vec("overrun_set", 32'(overrun), 32'h1);
        repeat (40) tick();
        check_vec("overrun_sticky", 32'(overrun), 32'h1);
        check_vec("overrun_no_stb", 32'(stb_cnt - start), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("overrun_clr", 32'(overrun), 32'h0);

        // Reset while the second product of a len=4 group is aligning
        start = stb_cnt;
        send(32'h3F800000, 8'd4);
        repeat (14) tick();
        send(32'h33800000, 8'd4);
        repeat (5) tick();
        check_vec("busy_align", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("busy_after_rst", 32'(busy), 32'h0);
        repeat (40) tick();
        check_vec("rst_no_stb", 32'(stb_cnt - start), 32'h0);

        start = stb_cnt;
        send(32'h40490FDB, 8'd1);
        wait_sum("pi_after_rst", start, 32'h40490FDB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
